// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM feeding a DEPTH-entry FIFO instruction queue for decode.
// Defining FETCH_PERF_EN adds a saturating redirect counter on redirect_count.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic [15:0] ir_pc,
  output logic [15:0] redirect_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {FETCH_IDLE, FETCH_REQ, FETCH_DISCARD} fetch_state_e;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc;
  } entry_t;

  fetch_state_e     state;
  logic [15:0]      fetch_pc;
  logic [15:0]      target_pc;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, head_n;
  logic [CNT_W-1:0] count, remain, count_n;
  logic             push, pop;
  entry_t           push_entry;

  // Redirect outranks both queue operations, so neither push nor pop fires with it.
  assign push       = (state == FETCH_REQ) && imem_resp && !redirect;
  assign pop        = ir_valid && ir_ready && !redirect;
  assign remain     = count - CNT_W'(pop);
  assign count_n    = remain + CNT_W'(push);
  assign head_n     = rd_ptr + PTR_W'(pop);
  assign target_pc  = redirect_pc & 16'hFFFE;
  assign push_entry = '{word: imem_rdata, pc: fetch_pc + 16'd2};
  assign opcode     = ir[15:12];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= FETCH_IDLE;
      fetch_pc     <= RESET_PC;
      imem_read    <= 1'b0;
      imem_address <= RESET_PC;
    end else begin
      unique case (state)
        FETCH_IDLE: begin
          if (redirect) begin
            fetch_pc <= target_pc;
          end else if (count < FULL) begin
            state        <= FETCH_REQ;
            imem_read    <= 1'b1;
            imem_address <= fetch_pc;
          end
        end
        FETCH_REQ: begin
          if (redirect) begin
            fetch_pc <= target_pc;
            if (imem_resp) begin
              state     <= FETCH_IDLE;
              imem_read <= 1'b0;
            end else begin
              state <= FETCH_DISCARD;
            end
          end else if (imem_resp) begin
            fetch_pc  <= fetch_pc + 16'd2;
            state     <= FETCH_IDLE;
            imem_read <= 1'b0;
          end
        end
        FETCH_DISCARD: begin
          // The in-flight read must still complete; its data is thrown away.
          if (redirect) fetch_pc <= target_pc;
          if (imem_resp) begin
            state     <= FETCH_IDLE;
            imem_read <= 1'b0;
          end
        end
        default: begin
          state     <= FETCH_IDLE;
          imem_read <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: queue storage has no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Head registers are loaded with the post-edge head, so ir never bypasses imem_rdata combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ir_valid <= 1'b0;
      ir       <= 16'h0000;
      ir_pc    <= 16'h0000;
    end else if (redirect) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ir_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr   <= head_n;
      count    <= count_n;
      ir_valid <= (count_n != '0);
      if (remain == '0 && push) begin
        ir    <= push_entry.word;
        ir_pc <= push_entry.pc;
      end else if (remain != '0) begin
        ir    <= mem[head_n].word;
        ir_pc <= mem[head_n].pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      redirect_count <= 16'h0000;
    else if (redirect && redirect_count != 16'hFFFF)
      redirect_count <= redirect_count + 16'd1;
  end
`else
  assign redirect_count = 16'h0000;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: DEPTH, 4, instruction queue entries (power of two, 2..8).
REQ-002 SHALL have parameter: RESET_PC, 16'h0000, first fetch address after reset.
REQ-003 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: imem_read  output  1  instruction memory read request.
REQ-006 SHALL have port: imem_address  output  16  word-aligned fetch address.
REQ-007 SHALL have port: imem_resp  input  1  one-cycle read completion pulse.
REQ-008 SHALL have port: imem_rdata  input  16  instruction word, valid with imem_resp.
REQ-009 SHALL have port: redirect  input  1  branch/jump/trap taken; flush and refetch.
REQ-010 SHALL have port: redirect_pc  input  16  new fetch address.
REQ-011 SHALL have port: ir_valid  output  1  queue head valid for decode.
REQ-012 SHALL have port: ir_ready  input  1  decode accepts head this cycle.
REQ-013 SHALL have port: ir  output  16  head instruction word.
REQ-014 SHALL have port: opcode  output  4  ir[15:12], lc3b_opcode-typed, feeds control decode.
REQ-015 SHALL have port: ir_pc  output  16  head instruction address + 2 (incremented PC).
REQ-016 SHALL have port: redirect_count  output  16  redirects taken (see Configuration).

Function
REQ-017 SHALL implement FSM states FETCH_IDLE, FETCH_REQ, FETCH_DISCARD.
REQ-018 FETCH_IDLE -> FETCH_REQ when queue count < DEPTH and no redirect; imem_read asserted from the next cycle.
REQ-019 In FETCH_REQ imem_read SHALL stay high and imem_address stable until imem_resp; at most one request outstanding.
REQ-020 On imem_resp in FETCH_REQ (no redirect): push {imem_rdata, fetch_pc+2}; fetch_pc += 2; go FETCH_IDLE.
REQ-021 fetch_pc arithmetic SHALL be 16-bit modulo: 16'hFFFE + 2 = 16'h0000.
REQ-022 Pushed entry SHALL appear at ir/ir_valid the cycle after imem_resp (no combinational bypass).
REQ-023 Pop SHALL occur when ir_valid && ir_ready; outputs then show next entry or ir_valid=0 if empty.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; order strictly FIFO.
REQ-025 Full queue (count = DEPTH): no new request issued; ir_valid=1.
REQ-026 Empty queue: ir_valid=0; ir, ir_pc, opcode hold last values; ir_ready ignored.
REQ-027 Redirect SHALL have priority over push and pop: queue flushed (ir_valid=0 next cycle), fetch_pc <= {redirect_pc[15:1],1'b0}.
REQ-028 Redirect while in FETCH_REQ without same-cycle imem_resp SHALL go FETCH_DISCARD; imem_read and old address held until imem_resp; that data dropped; then FETCH_IDLE.
REQ-029 Redirect with same-cycle imem_resp SHALL drop the data and go FETCH_IDLE.
REQ-030 Redirect during FETCH_DISCARD SHALL update fetch_pc only; remain until imem_resp.
REQ-031 From FETCH_IDLE after redirect, imem_read with new address SHALL assert on the next cycle.

Reset
REQ-032 reset_n low SHALL asynchronously set: state FETCH_IDLE, fetch_pc=RESET_PC, count=0, ir_valid=0, imem_read=0, ir=16'h0000, ir_pc=16'h0000, redirect_count=0.
REQ-033 Reset asserted mid-request SHALL abandon the request; any imem_resp before the first post-reset request SHALL be ignored.

Configuration
REQ-034 Macro FETCH_PERF_EN defined: redirect_count increments (saturating at 16'hFFFF) on every cycle with redirect=1.
REQ-035 FETCH_PERF_EN undefined: redirect_count tied to 16'h0000, counter logic absent; all other behaviour identical.

Verification
REQ-036 Reset, imem_resp 1-cycle latency, rdata 16'h1261, ir_ready=1 -> first imem_address 16'h0000; ir=16'h1261, opcode=4'b0001, ir_pc=16'h0002 one cycle after resp.
REQ-037 ir_ready=0, 6 fetches -> exactly 4 entries queued, imem_read low after 4th resp; release ready -> 4 words in order, addresses 0,2,4,6 then fetch resumes at 16'h0008.
REQ-038 Redirect to 16'h3001 while request to 16'h0004 outstanding, resp 3 cycles later -> that data dropped, next imem_address 16'h3000, ir_valid=0 until its resp.
REQ-039 Redirect and imem_resp same cycle -> no push; next request to redirect_pc; queue empty.
REQ-040 fetch_pc 16'hFFFE fetched -> ir_pc=16'h0000, next address 16'h0000.
REQ-041 With FETCH_PERF_EN, 3 redirects -> redirect_count=3; without, stays 0; reset_n pulsed mid-request -> all outputs at REQ-032 values immediately.
